pwm_capture: RTL and testbench

- Measures an incoming PWM waveform and reports, per PWM period, the high-time and period length in clock cycles.
- Receive-side counterpart of the 8-bit PWM controller: it checks generated PWM in loopback and decodes external PWM command inputs.
- Detects a missing rising edge (0 % or 100 % duty, dead source) and flags stuck-low or stuck-high.
- Downstream logic consumes one single-cycle result pulse per period.

---
 rtl/pwm_capture_pkg.sv | 22 ++
 rtl/pwm_capture_if.sv | 45 ++++
 rtl/pwm_edge_sync.sv | 38 +++
 rtl/pwm_capture.sv | 179 +++++++++++++++++
 tb/tb_pwm_capture.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_capture_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the PWM capture block and its 8-bit PWM generator
// counterpart: FSM state encoding, default counter width / timeout and the
// nominal generator period.
// ---------------------------------------------------------------------------
package pwm_pkg;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_TIMEOUT     = 512;
    localparam int DEF_SYNC_STAGES = 2;

    // Period of the 8-bit PWM generator, in clk cycles.
    localparam int PWM_PERIOD      = 256;

    typedef enum logic [1:0] {
        DISABLED  = 2'd0,   // capture off, accumulators cleared
        ARMING    = 2'd1,   // waiting for the first rising edge
        MEASURING = 2'd2    // timing a period between two rising edges
    } pwm_state_t;

endpackage

// File: rtl/pwm_capture_if.sv
// ---------------------------------------------------------------------------
// pwm_capture_if
// Signal bundle between a PWM capture block and its user.
//   enable       capture enable (user -> capture)
//   pwm_in       PWM waveform, may be asynchronous (user -> capture)
//   high_cnt     high cycles of the last completed period
//   period_cnt   length of the last completed period
//   meas_valid   one-cycle pulse when high_cnt/period_cnt update
//   stuck        no rising edge seen for the timeout interval
//   stuck_level  synchronised input level when stuck was raised
// master: the user side; slave: the capture block.
// ---------------------------------------------------------------------------
interface pwm_capture_if #(
    parameter int CNT_W = pwm_pkg::DEF_CNT_W
);

    logic             enable;
    logic             pwm_in;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic             meas_valid;
    logic             stuck;
    logic             stuck_level;

    modport master (
        output enable,
        output pwm_in,
        input  high_cnt,
        input  period_cnt,
        input  meas_valid,
        input  stuck,
        input  stuck_level
    );

    modport slave (
        input  enable,
        input  pwm_in,
        output high_cnt,
        output period_cnt,
        output meas_valid,
        output stuck,
        output stuck_level
    );

endinterface

// File: rtl/pwm_edge_sync.sv
// ---------------------------------------------------------------------------
// pwm_edge_sync
// Brings an asynchronous PWM input into the clk domain and flags rising edges.
//   clk      system clock
//   rst      synchronous active-low reset (clears every flop)
//   pwm_in   raw PWM input
//   pwm_s    synchronised level (last stage of the chain)
//   rise     pwm_s is high and was low in the previous cycle
// Rising and falling transitions travel through the same chain, so measured
// high and period times carry no relative offset.
// ---------------------------------------------------------------------------
module pwm_edge_sync #(
    parameter int SYNC_STAGES = 2   // must be >= 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic pwm_s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   pwm_d_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_reg  <= '0;
            pwm_d_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], pwm_in};
            pwm_d_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign pwm_s = sync_reg[SYNC_STAGES-1];
    assign rise  = pwm_s & ~pwm_d_reg;

endmodule

// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
// Measures an incoming PWM waveform: per period (rising edge to rising edge)
// it reports the number of high cycles and the period length, with a
// one-cycle meas_valid pulse. A missing rising edge for TIMEOUT cycles raises
// stuck and records the input level at that moment.
//   clk    system clock
//   rst    synchronous active-low reset
//   bus    pwm_capture_if.slave: enable, pwm_in in; high_cnt, period_cnt,
//          meas_valid, stuck, stuck_level out
// TIMEOUT must lie in [2, 2^CNT_W-1]; the timeout then always fires before
// an accumulator could reach saturation.
// ---------------------------------------------------------------------------
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic          clk,
    input  logic          rst,
    pwm_capture_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    logic pwm_s;
    logic rise;

    pwm_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (bus.pwm_in),
        .pwm_s  (pwm_s),
        .rise   (rise)
    );

    pwm_state_t       state_reg,       state_next;
    logic [CNT_W-1:0] high_acc_reg,    high_acc_next;
    logic [CNT_W-1:0] period_acc_reg,  period_acc_next;
    logic [CNT_W-1:0] tmo_reg,         tmo_next;
    logic [CNT_W-1:0] high_cnt_reg,    high_cnt_next;
    logic [CNT_W-1:0] period_cnt_reg,  period_cnt_next;
    logic             meas_valid_reg,  meas_valid_next;
    logic             stuck_reg,       stuck_next;
    logic             stuck_level_reg, stuck_level_next;

    // tmo_reg counts cycles since the last rise (or since entering ARMING);
    // it is cleared at those points, so the last count value before expiry
    // is TIMEOUT-1.
    logic timeout_hit;
    assign timeout_hit = (tmo_reg == TMO_LAST);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= DISABLED;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_next       = state_reg;
        high_acc_next    = high_acc_reg;
        period_acc_next  = period_acc_reg;
        tmo_next         = tmo_reg;
        high_cnt_next    = high_cnt_reg;
        period_cnt_next  = period_cnt_reg;
        meas_valid_next  = 1'b0;
        stuck_next       = stuck_reg;
        stuck_level_next = stuck_level_reg;

        if (!bus.enable) begin
            // Results and stuck_level hold; everything else restarts.
            state_next      = DISABLED;
            high_acc_next   = '0;
            period_acc_next = '0;
            tmo_next        = '0;
            stuck_next      = 1'b0;
        end else begin
            case (state_reg)
                DISABLED: begin
                    state_next      = ARMING;
                    high_acc_next   = '0;
                    period_acc_next = '0;
                    tmo_next        = '0;
                end

                ARMING: begin
                    if (rise) begin
                        // First edge only starts the window; no result yet.
                        state_next      = MEASURING;
                        high_acc_next   = CNT_ONE;
                        period_acc_next = CNT_ONE;
                        tmo_next        = '0;
                        stuck_next      = 1'b0;
                    end else if (timeout_hit) begin
                        stuck_next       = 1'b1;
                        stuck_level_next = pwm_s;
                        high_acc_next    = '0;
                        period_acc_next  = '0;
                        tmo_next         = '0;
                    end else begin
                        tmo_next = tmo_reg + CNT_ONE;
                    end
                end

                MEASURING: begin
                    // A rise in the same cycle as expiry takes priority.
                    if (rise) begin
                        high_cnt_next   = high_acc_reg;
                        period_cnt_next = period_acc_reg;
                        meas_valid_next = 1'b1;
                        high_acc_next   = CNT_ONE;
                        period_acc_next = CNT_ONE;
                        tmo_next        = '0;
                    end else if (timeout_hit) begin
                        state_next       = ARMING;
                        stuck_next       = 1'b1;
                        stuck_level_next = pwm_s;
                        high_acc_next    = '0;
                        period_acc_next  = '0;
                        tmo_next         = '0;
                    end else begin
                        period_acc_next = sat_inc(period_acc_reg);
                        if (pwm_s) begin
                            high_acc_next = sat_inc(high_acc_reg);
                        end
                        tmo_next = tmo_reg + CNT_ONE;
                    end
                end

                default: begin
                    state_next = DISABLED;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            high_acc_reg    <= '0;
            period_acc_reg  <= '0;
            tmo_reg         <= '0;
            high_cnt_reg    <= '0;
            period_cnt_reg  <= '0;
            meas_valid_reg  <= 1'b0;
            stuck_reg       <= 1'b0;
            stuck_level_reg <= 1'b0;
        end else begin
            high_acc_reg    <= high_acc_next;
            period_acc_reg  <= period_acc_next;
            tmo_reg         <= tmo_next;
            high_cnt_reg    <= high_cnt_next;
            period_cnt_reg  <= period_cnt_next;
            meas_valid_reg  <= meas_valid_next;
            stuck_reg       <= stuck_next;
            stuck_level_reg <= stuck_level_next;
        end
    end

    assign bus.high_cnt    = high_cnt_reg;
    assign bus.period_cnt  = period_cnt_reg;
    assign bus.meas_valid  = meas_valid_reg;
    assign bus.stuck       = stuck_reg;
    assign bus.stuck_level = stuck_level_reg;

endmodule

// File: tb/tb_pwm_capture.sv
// ---------------------------------------------------------------------------
// tb_pwm_capture
// Drives pwm_capture from an 8-bit PWM generator model (duty latched at the
// period boundary), checks a table of duty settings, hand-written corner
// sequences (stuck low/high, enable drop, reset pulse) and a random run.
// Every driven level and enable/reset value is logged per cycle; at the end
// the expected measurement list is derived from that log (rise-to-rise
// windows, delayed by the synchroniser) and compared with what was observed.
// ---------------------------------------------------------------------------
module tb_pwm_capture;
    import pwm_pkg::*;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 512;
    localparam int SYNC    = 2;
    localparam int MAXC    = 32768;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pwm_capture_if #(.CNT_W(CNT_W)) bus ();

    pwm_capture #(
        .CNT_W       (CNT_W),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int cyc;
        int high;
        int period;
    } meas_t;

    typedef struct {
        int duty;
        int exp_high;
        int exp_period;
    } vec_t;

    int    cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    meas_t obs_q[$];
    meas_t exp_q[$];
    meas_t mon_tmp;

    always @(negedge clk) begin
        if (bus.meas_valid === 1'b1) begin
            mon_tmp.cyc    = cyc;
            mon_tmp.high   = int'(bus.high_cnt);
            mon_tmp.period = int'(bus.period_cnt);
            obs_q.push_back(mon_tmp);
        end
    end

    bit h_hist  [MAXC];
    bit en_hist [MAXC];

    int duty     = 0;
    int duty_act = 0;
    int gen_cnt  = 0;
    bit force_hi = 1'b0;
    bit en_v     = 1'b0;
    bit rst_v    = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: apply inputs just after the edge, then log what was driven.
    task automatic step();
        @(posedge clk);
        #1;
        bus.enable = en_v;
        rst        = rst_v;
        if (gen_cnt == 0) duty_act = duty;
        bus.pwm_in = force_hi ? 1'b1 : (gen_cnt < duty_act);
        gen_cnt    = (gen_cnt + 1) % PWM_PERIOD;
        if (cyc < MAXC) begin
            h_hist[cyc]  = bus.pwm_in;
            en_hist[cyc] = en_v && rst_v;
            // A reset edge also empties the synchroniser: the two levels in
            // flight at that moment never reach the capture logic.
            if (!rst_v) begin
                h_hist[cyc] = 1'b0;
                if (cyc > 0) h_hist[cyc-1] = 1'b0;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_meas(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (bus.meas_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_stuck(input bit lvl, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (bus.stuck === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_high_cnt"},    int'(bus.high_cnt),    0);
        check({tag, "_period_cnt"},  int'(bus.period_cnt),  0);
        check({tag, "_meas_valid"},  int'(bus.meas_valid),  0);
        check({tag, "_stuck"},       int'(bus.stuck),       0);
        check({tag, "_stuck_level"}, int'(bus.stuck_level), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    vec_t  vecs [5];
    bit    ok;
    int    n_en, sz, t0, r, len, n_end, last_eff, hsum, nmin;
    bit    cont;
    meas_t e, o, p;

    initial begin
        vecs[0] = '{64,  64,  PWM_PERIOD};
        vecs[1] = '{128, 128, PWM_PERIOD};
        vecs[2] = '{255, 255, PWM_PERIOD};
        vecs[3] = '{1,   1,   PWM_PERIOD};
        vecs[4] = '{200, 200, PWM_PERIOD};

        bus.enable = 1'b0;
        bus.pwm_in = 1'b0;

        // Reset state
        run(4);
        check_reset_outputs("reset");
        rst_v = 1'b1;
        run(2);

        // Table of steady duty cycles
        en_v = 1'b1;
        foreach (vecs[i]) begin
            duty = vecs[i].duty;
            run(800);
            check($sformatf("tbl%0d_nevents_ge2", i), int'(obs_q.size() >= 2), 1);
            if (obs_q.size() >= 2) begin
                o = obs_q[obs_q.size()-1];
                p = obs_q[obs_q.size()-2];
                check($sformatf("tbl%0d_high", i),   o.high,   vecs[i].exp_high);
                check($sformatf("tbl%0d_period", i), o.period, vecs[i].exp_period);
                check($sformatf("tbl%0d_spacing", i), o.cyc - p.cyc, PWM_PERIOD);
            end
        end

        // Duty 0: no measurement, stuck low exactly TIMEOUT cycles into ARMING
        en_v = 1'b0;
        duty = 0;
        run(300);
        sz   = obs_q.size();
        en_v = 1'b1;
        step();
        n_en = cyc;
        while (cyc < n_en + TIMEOUT) step();
        check("stuck_lo_not_early", int'(bus.stuck), 0);
        step();
        check("stuck_lo_set", int'(bus.stuck), 1);
        check("stuck_lo_level", int'(bus.stuck_level), 0);
        check("stuck_lo_no_meas", obs_q.size(), sz);

        duty = 64;
        wait_stuck(1'b0, 600, ok);
        check("stuck_lo_cleared", int'(ok), 1);
        wait_meas(600, ok);
        check("after_lo_meas_seen", int'(ok), 1);
        check("after_lo_high", int'(bus.high_cnt), 64);
        check("after_lo_period", int'(bus.period_cnt), PWM_PERIOD);

        // Input held high
        force_hi = 1'b1;
        wait_stuck(1'b1, 800, ok);
        check("stuck_hi_set", int'(ok), 1);
        check("stuck_hi_level", int'(bus.stuck_level), 1);
        force_hi = 1'b0;
        wait_meas(800, ok);
        check("after_hi_meas_seen", int'(ok), 1);
        check("after_hi_high", int'(bus.high_cnt), 64);
        check("after_hi_period", int'(bus.period_cnt), PWM_PERIOD);
        check("after_hi_stuck", int'(bus.stuck), 0);

        // Enable dropped mid-period for 10 cycles
        wait_meas(600, ok);
        check("en_pre_meas_seen", int'(ok), 1);
        run(100);
        en_v = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("en_low_meas_valid", int'(bus.meas_valid), 0);
            check("en_low_high_hold", int'(bus.high_cnt), 64);
            check("en_low_period_hold", int'(bus.period_cnt), PWM_PERIOD);
        end
        en_v = 1'b1;
        t0   = cyc;
        wait_meas(700, ok);
        check("en_post_meas_seen", int'(ok), 1);
        check("en_post_two_rises", int'((cyc - t0) > PWM_PERIOD), 1);
        check("en_post_high", int'(bus.high_cnt), 64);
        check("en_post_period", int'(bus.period_cnt), PWM_PERIOD);

        // One-cycle reset mid-period
        wait_meas(600, ok);
        check("rst_pre_meas_seen", int'(ok), 1);
        run(100);
        rst_v = 1'b0;
        step();
        rst_v = 1'b1;
        step();
        check_reset_outputs("midrst");
        wait_meas(900, ok);
        check("rst_post_meas_seen", int'(ok), 1);
        check("rst_post_high", int'(bus.high_cnt), 64);
        check("rst_post_period", int'(bus.period_cnt), PWM_PERIOD);

        // Random segments: duty, forced-high, enable drops, reset pulses
        for (int s = 0; s < 20; s++) begin
            r   = int'($urandom_range(0, 99));
            len = int'($urandom_range(150, 900));
            if (r < 8) duty = 0;
            else       duty = int'($urandom_range(1, 255));
            force_hi = (r >= 8 && r < 13);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 399) == 0) begin
                    en_v = 1'b0;
                    run(int'($urandom_range(1, 15)));
                    en_v = 1'b1;
                end
                if ($urandom_range(0, 1999) == 0) rst_v = 1'b0;
                step();
                rst_v = 1'b1;
            end
            force_hi = 1'b0;
        end
        en_v = 1'b0;
        run(10);

        // Reference: each period is a pair of consecutive accepted rising
        // edges of the driven waveform, seen SYNC+1 cycles later.
        n_end    = (cyc < MAXC) ? cyc : MAXC;
        last_eff = -1;
        for (int m = 1; m + SYNC < n_end; m++) begin
            if (h_hist[m] && !h_hist[m-1]) begin
                int c;
                c = m + SYNC;    // cycle in which the capture logic sees it
                if (en_hist[c-1] && en_hist[c]) begin
                    if (last_eff >= 0 && (m - last_eff) <= TIMEOUT) begin
                        cont = 1'b1;
                        for (int k = last_eff + SYNC; k <= c; k++)
                            if (!en_hist[k]) cont = 1'b0;
                        if (cont) begin
                            hsum = 0;
                            for (int k = last_eff; k < m; k++) hsum += int'(h_hist[k]);
                            e.cyc    = c + 1;
                            e.high   = hsum;
                            e.period = m - last_eff;
                            exp_q.push_back(e);
                        end
                    end
                    last_eff = m;
                end
            end
        end

        check("model_event_count", obs_q.size(), exp_q.size());
        nmin = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) begin
            check($sformatf("ev%0d_cycle", i),  obs_q[i].cyc,    exp_q[i].cyc);
            check($sformatf("ev%0d_high", i),   obs_q[i].high,   exp_q[i].high);
            check($sformatf("ev%0d_period", i), obs_q[i].period, exp_q[i].period);
            check($sformatf("ev%0d_high_le_period", i),
                  int'(obs_q[i].high <= obs_q[i].period), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
